vote_tally: RTL and testbench



---
 rtl/vote_pkg.sv | 42 ++++
 rtl/sat_counter.sv | 32 +++
 rtl/vote_tally.sv | 144 ++++++++++++++
 tb/tb_vote_tally.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : vote_pkg
// Brief   : Shared types and helpers for the vote tally block: FSM state
//           encoding and a one-hot decoder for the candidate pulse vector.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package vote_pkg;

  // Widest candidate vector the decoder handles (NUM_CAND legal up to 8).
  localparam int MAX_CAND = 8;
  localparam int IDX_W    = 3;

  typedef enum logic [1:0] {
    S_VOTE   = 2'd0,
    S_ACK    = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  typedef struct packed {
    logic             is_single;
    logic [IDX_W-1:0] idx;
  } onehot_t;

  // Reports whether exactly one bit is set and, if so, which one.
  function automatic onehot_t onehot_idx(input logic [MAX_CAND-1:0] v);
    onehot_t r;
    int      cnt;
    r   = '0;
    cnt = 0;
    for (int i = 0; i < MAX_CAND; i++) begin
      if (v[i]) begin
        cnt   = cnt + 1;
        r.idx = IDX_W'(i);
      end
    end
    r.is_single = (cnt == 1);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : sat_counter
// Brief   : Up-counter with increment enable and synchronous clear that
//           holds at its maximum value instead of wrapping.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Count up on enable, clamping at all-ones.
  always_ff @(posedge clock) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/vote_tally.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : vote_tally
// Brief   : Counts qualified single-candidate votes, holds an LED acknowledge
//           for a fixed time after each vote and shows a selected candidate's
//           tally on the LEDs in result mode.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module vote_tally
  import vote_pkg::*;
#(
  parameter int NUM_CAND   = 4,
  parameter int CNT_W      = 8,
  parameter int ACK_CYCLES = 50000000,
  parameter int TOT_W      = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic [NUM_CAND-1:0] valid_vote,
  output logic [CNT_W-1:0]    leds,
  output logic                vote_ack,
  output logic                vote_reject,
  output logic [TOT_W-1:0]    total_votes,
  output logic [1:0]          state_o
);

  localparam int SEL_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int TMR_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(ACK_CYCLES - 1);

  state_t             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   leds_q;
  logic               ack_q;
  logic               rej_q;

  logic [MAX_CAND-1:0] vv_ext;
  onehot_t             oh;
  logic                multi;
  logic                accept;
  logic [NUM_CAND-1:0] tally_inc;
  logic [CNT_W-1:0]    tally_cnt [NUM_CAND];
  logic [CNT_W-1:0]    sel_cnt;

  assign vv_ext  = MAX_CAND'(valid_vote);
  assign oh      = onehot_idx(vv_ext);
  assign multi   = (|valid_vote) && !oh.is_single;
  // Votes are only counted while waiting for a voter.
  assign accept  = (state_q == S_VOTE) && oh.is_single;
  assign sel_cnt = tally_cnt[sel_q];

  generate
    for (genvar i = 0; i < NUM_CAND; i++) begin : g_tally
      assign tally_inc[i] = accept && (oh.idx == IDX_W'(i));
      sat_counter #(.WIDTH(CNT_W)) u_cnt (
        .clock (clock),
        .reset (reset),
        .clr_i (1'b0),
        .inc_i (tally_inc[i]),
        .cnt_o (tally_cnt[i])
      );
    end
  endgenerate

  sat_counter #(.WIDTH(TOT_W)) u_total (
    .clock (clock),
    .reset (reset),
    .clr_i (1'b0),
    .inc_i (accept),
    .cnt_o (total_votes)
  );

  // FSM, ack timer, candidate select and registered LED / pulse outputs.
  // LEDs are driven from the state being entered so they track state_o.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_VOTE;
      timer_q <= '0;
      sel_q   <= '0;
      leds_q  <= '0;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      rej_q <= 1'b0;
      case (state_q)
        S_VOTE: begin
          if (oh.is_single) begin
            ack_q   <= 1'b1;
            timer_q <= TMR_INIT;
            state_q <= S_ACK;
            leds_q  <= '1;
          end else if (multi) begin
            rej_q  <= 1'b1;
            leds_q <= '0;
          end else if (mode) begin
            state_q <= S_RESULT;
            leds_q  <= sel_cnt;
          end else begin
            leds_q <= '0;
          end
        end
        S_ACK: begin
          if (timer_q == '0) begin
            if (mode) begin
              state_q <= S_RESULT;
              leds_q  <= sel_cnt;
            end else begin
              state_q <= S_VOTE;
              leds_q  <= '0;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
            leds_q  <= '1;
          end
        end
        S_RESULT: begin
          if (!mode) begin
            state_q <= S_VOTE;
            leds_q  <= '0;
          end else begin
            if (oh.is_single) begin
              sel_q <= oh.idx[SEL_W-1:0];
            end
            leds_q <= sel_cnt;
          end
        end
        default: begin
          state_q <= S_VOTE;
          leds_q  <= '0;
        end
      endcase
    end
  end

  assign leds        = leds_q;
  assign vote_ack    = ack_q;
  assign vote_reject = rej_q;
  assign state_o     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_tally.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_vote_tally
// Brief   : Directed self-checking bench for vote_tally.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_vote_tally;

  logic       clock;
  logic       reset;
  logic       mode;
  logic [3:0] valid_vote;
  logic [7:0] leds;
  logic       vote_ack;
  logic       vote_reject;
  logic [9:0] total_votes;
  logic [1:0] state_o;

  int total;
  int bad;

  vote_tally #(
    .NUM_CAND   (4),
    .CNT_W      (8),
    .ACK_CYCLES (4),
    .TOT_W      (10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .valid_vote  (valid_vote),
    .leds        (leds),
    .vote_ack    (vote_ack),
    .vote_reject (vote_reject),
    .total_votes (total_votes),
    .state_o     (state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    mode       = 1'b0;
    valid_vote = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic vote(input logic [3:0] v);
    valid_vote = v;
    tick();
    valid_vote = 4'b0000;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (state_o !== 2'd0 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (state_o !== 2'd0) begin
      bad++;
      $display("FAIL %s_idle_timeout: state=%0d want 0", name, state_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 1'b0; valid_vote = 4'b0000;
    tick(); tick();
    total++;
    if (state_o !== 2'd0 || leds !== 8'h00 || vote_ack !== 1'b0 ||
        vote_reject !== 1'b0 || total_votes !== 10'd0) begin
      bad++;
      $display("FAIL reset_values: state=%0d leds=%h ack=%b rej=%b tot=%0d want 0/00/0/0/0",
               state_o, leds, vote_ack, vote_reject, total_votes);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_vote();
    do_reset();
    vote(4'b0001);
    total++;
    if (vote_ack !== 1'b1 || total_votes !== 10'd1 || leds !== 8'hFF || state_o !== 2'd1) begin
      bad++;
      $display("FAIL single_vote_resp: ack=%b tot=%0d leds=%h state=%0d want 1/1/ff/1",
               vote_ack, total_votes, leds, state_o);
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      total++;
      if (leds !== 8'hFF || vote_ack !== 1'b0) begin
        bad++;
        $display("FAIL ack_hold_cycle%0d: leds=%h ack=%b want ff/0", k, leds, vote_ack);
      end
    end
    tick();
    total++;
    if (leds !== 8'h00 || state_o !== 2'd0) begin
      bad++;
      $display("FAIL ack_end: leds=%h state=%0d want 00/0", leds, state_o);
    end
    mode = 1'b1;
    tick();
    total++;
    if (state_o !== 2'd2 || leds !== 8'h01) begin
      bad++;
      $display("FAIL tally0_readout: state=%0d leds=%h want 2/01", state_o, leds);
    end
    mode = 1'b0;
    tick();
  endtask

  task automatic test_reject_and_ignore();
    do_reset();
    vote(4'b0110);
    total++;
    if (vote_reject !== 1'b1 || vote_ack !== 1'b0 || state_o !== 2'd0 || total_votes !== 10'd0) begin
      bad++;
      $display("FAIL reject_resp: rej=%b ack=%b state=%0d tot=%0d want 1/0/0/0",
               vote_reject, vote_ack, state_o, total_votes);
    end
    tick();
    total++;
    if (vote_reject !== 1'b0) begin
      bad++;
      $display("FAIL reject_one_cycle: rej=%b want 0", vote_reject);
    end
    vote(4'b0001);
    vote(4'b0010);
    total++;
    if (vote_ack !== 1'b0 || vote_reject !== 1'b0 || state_o !== 2'd1 || total_votes !== 10'd1) begin
      bad++;
      $display("FAIL ack_ignores_vote: ack=%b rej=%b state=%0d tot=%0d want 0/0/1/1",
               vote_ack, vote_reject, state_o, total_votes);
    end
    wait_idle("reject");
    mode = 1'b1;
    tick();
    vote(4'b0010);
    tick();
    total++;
    if (leds !== 8'h00 || total_votes !== 10'd1) begin
      bad++;
      $display("FAIL tally1_unchanged: leds=%h tot=%0d want 00/1", leds, total_votes);
    end
    mode = 1'b0;
    tick();
  endtask

  task automatic test_result_select();
    do_reset();
    repeat (3) begin
      vote(4'b0100);
      wait_idle("sel_c2");
    end
    vote(4'b1000);
    wait_idle("sel_c3");
    mode = 1'b1;
    tick();
    total++;
    if (state_o !== 2'd2 || leds !== 8'h00 || total_votes !== 10'd4) begin
      bad++;
      $display("FAIL result_entry: state=%0d leds=%h tot=%0d want 2/00/4", state_o, leds, total_votes);
    end
    vote(4'b0100);
    total++;
    if (leds !== 8'h00) begin
      bad++;
      $display("FAIL sel_latency: leds=%h want 00", leds);
    end
    tick();
    total++;
    if (leds !== 8'h03) begin
      bad++;
      $display("FAIL show_c2: leds=%h want 03", leds);
    end
    vote(4'b1000);
    tick();
    total++;
    if (leds !== 8'h01) begin
      bad++;
      $display("FAIL show_c3: leds=%h want 01", leds);
    end
    vote(4'b1100);
    tick();
    total++;
    if (leds !== 8'h01 || vote_reject !== 1'b0 || total_votes !== 10'd4) begin
      bad++;
      $display("FAIL result_multi_ignored: leds=%h rej=%b tot=%0d want 01/0/4",
               leds, vote_reject, total_votes);
    end
    mode = 1'b0;
    tick();
    total++;
    if (leds !== 8'h00 || state_o !== 2'd0) begin
      bad++;
      $display("FAIL result_exit: leds=%h state=%0d want 00/0", leds, state_o);
    end
    mode = 1'b1;
    tick();
    total++;
    if (leds !== 8'h01) begin
      bad++;
      $display("FAIL sel_retained: leds=%h want 01", leds);
    end
    mode = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    int missing;
    do_reset();
    missing = 0;
    for (int k = 0; k < 260; k++) begin
      vote(4'b0001);
      total++;
      if (vote_ack !== 1'b1) begin
        bad++;
        missing++;
        if (missing < 5) $display("FAIL sat_ack_vote%0d: ack=%b want 1", k, vote_ack);
      end
      wait_idle("sat");
    end
    total++;
    if (total_votes !== 10'h104) begin
      bad++;
      $display("FAIL sat_total: tot=%h want 104", total_votes);
    end
    mode = 1'b1;
    tick();
    total++;
    if (leds !== 8'hFF) begin
      bad++;
      $display("FAIL sat_tally0: leds=%h want ff", leds);
    end
    mode = 1'b0;
    tick();
  endtask

  task automatic test_vote_and_mode();
    do_reset();
    mode = 1'b1;
    vote(4'b0001);
    total++;
    if (vote_ack !== 1'b1 || state_o !== 2'd1 || total_votes !== 10'd1) begin
      bad++;
      $display("FAIL vote_priority: ack=%b state=%0d tot=%0d want 1/1/1", vote_ack, state_o, total_votes);
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      total++;
      if (state_o !== 2'd1) begin
        bad++;
        $display("FAIL vm_ack_dwell%0d: state=%0d want 1", k, state_o);
      end
    end
    tick();
    total++;
    if (state_o !== 2'd2 || leds !== 8'h01) begin
      bad++;
      $display("FAIL ack_to_result: state=%0d leds=%h want 2/01", state_o, leds);
    end
    mode = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_ack();
    do_reset();
    vote(4'b0010);
    wait_idle("rst_pre");
    vote(4'b0001);
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (state_o !== 2'd0 || leds !== 8'h00 || vote_ack !== 1'b0 || total_votes !== 10'd0) begin
      bad++;
      $display("FAIL reset_mid_ack: state=%0d leds=%h ack=%b tot=%0d want 0/00/0/0",
               state_o, leds, vote_ack, total_votes);
    end
    reset = 1'b0;
    tick();
    total++;
    if (vote_ack !== 1'b0 || state_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_no_pending: ack=%b state=%0d want 0/0", vote_ack, state_o);
    end
    mode = 1'b1;
    tick();
    total++;
    if (leds !== 8'h00) begin
      bad++;
      $display("FAIL reset_tally0: leds=%h want 00", leds);
    end
    vote(4'b0010);
    tick();
    total++;
    if (leds !== 8'h00) begin
      bad++;
      $display("FAIL reset_tally1: leds=%h want 00", leds);
    end
    mode = 1'b0;
    tick();
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    mode       = 1'b0;
    valid_vote = 4'b0000;
    test_reset();
    test_single_vote();
    test_reject_and_ignore();
    test_result_select();
    test_saturation();
    test_vote_and_mode();
    test_reset_mid_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
